// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory port owner: arbitrates loader writes against pipeline fetch,
// maintains the PC and registers the fetched word toward decode.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  input  logic             ld_done,
  input  logic             fe_stall,
  input  logic             fe_redirect,
  input  logic [31:0]      fe_target,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             align_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    LOAD = 2'b10
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // ld_ready is registered and low in RUN, so gating the write with it keeps
  // the memory write-free during fetch and during reset.
  assign mem_addr = (state == RUN) ? pc : ld_addr;
  assign mem_we   = ld_ready & ld_valid;
  assign mem_wd   = ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ld_ready    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      align_err   <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        BOOT: begin
          ld_ready    <= 1'b1;
          instr_valid <= 1'b0;
          if (ld_done) begin
            state    <= RUN;
            pc       <= RESET_PC;
            ld_ready <= 1'b0;
          end
        end
        RUN: begin
          // Redirect wins over both stall and a pending loader request.
          if (fe_redirect) begin
            pc          <= {fe_target[31:2], 2'b00};
            instr_valid <= 1'b0;
            if (fe_target[1:0] != 2'b00) align_err <= 1'b1;
          end else if (!fe_stall) begin
            instr       <= mem_rd;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            if (ld_valid) begin
              state    <= LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          if (!ld_valid) begin
            state    <= RUN;
            ld_ready <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          ld_ready <= 1'b0;
        end
      endcase

      if (state == RUN && instr_valid && !fe_stall) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a small behavioural instruction memory.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        fe_stall;
  logic        fe_redirect;
  logic [31:0] fe_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        align_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  imem_fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .fe_stall(fe_stall), .fe_redirect(fe_redirect), .fe_target(fe_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .align_err(align_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
  assign mem_rd = mem[mem_addr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic done);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
    #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL boot_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== a) begin failures++; $display("FAIL boot_addr got=%h exp=%h", mem_addr, a); end
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    fe_stall = 1'b0; fe_redirect = 1'b0; fe_target = '0;
    tick(); tick();
    checks++; if ({instr_valid, ld_ready, mem_we, align_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {instr_valid, ld_ready, mem_we, align_err}); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", instr, instr_pc); end
    checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    tick();
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL boot_ready got=%b exp=1", ld_ready); end
    load_word(32'h0000_0100, 32'h5A, 1'b0);
    load_word(32'hFFFF_FFFC, 32'hEE, 1'b0);
    load_word(32'h0, 32'h11, 1'b0);
    load_word(32'h4, 32'h22, 1'b0);
    load_word(32'h8, 32'h33, 1'b1);
    checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL run_ready got=%b/%b exp=0/0", ld_ready, mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL run_pc0 got=%h exp=0", mem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h11 || instr_pc !== 32'h0) begin
      failures++; $display("FAIL fetch0 got=%b %h@%h exp=1 11@0", instr_valid, instr, instr_pc); end
    tick();
    checks++; if (instr !== 32'h22 || instr_pc !== 32'h4) begin
      failures++; $display("FAIL fetch1 got=%h@%h exp=22@4", instr, instr_pc); end
    checks++; if (fetch_cnt !== 32'd1) begin failures++; $display("FAIL boot_cnt got=%0d exp=1", fetch_cnt); end
  endtask

  task automatic test_stall();
    fe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr !== 32'h22 || instr_pc !== 32'h4 || instr_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold got=%b %h@%h exp=1 22@4", instr_valid, instr, instr_pc); end
      checks++; if (mem_addr !== 32'h8 || fetch_cnt !== 32'd1) begin
        failures++; $display("FAIL stall_pc_cnt got=%h/%0d exp=8/1", mem_addr, fetch_cnt); end
    end
    fe_stall = 1'b0;
    tick();
    checks++; if (instr !== 32'h33 || instr_pc !== 32'h8 || fetch_cnt !== 32'd2) begin
      failures++; $display("FAIL stall_resume got=%h@%h cnt=%0d exp=33@8 cnt=2", instr, instr_pc, fetch_cnt); end
  endtask

  task automatic test_redirect();
    fe_redirect = 1'b1; fe_target = 32'h102; fe_stall = 1'b1;
    tick();
    fe_redirect = 1'b0; fe_stall = 1'b0;
    checks++; if (instr_valid !== 1'b0 || align_err !== 1'b1) begin
      failures++; $display("FAIL redir_bubble got=%b/%b exp=0/1", instr_valid, align_err); end
    checks++; if (mem_addr !== 32'h100 || fetch_cnt !== 32'd2) begin
      failures++; $display("FAIL redir_pc got=%h cnt=%0d exp=100 cnt=2", mem_addr, fetch_cnt); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h5A || instr_pc !== 32'h100) begin
      failures++; $display("FAIL redir_fetch got=%b %h@%h exp=1 5a@100", instr_valid, instr, instr_pc); end
    tick();
    checks++; if (instr_pc !== 32'h104 || fetch_cnt !== 32'd3) begin
      failures++; $display("FAIL redir_next got=%h cnt=%0d exp=104 cnt=3", instr_pc, fetch_cnt); end
  endtask

  task automatic test_live_load();
    fe_redirect = 1'b1; fe_target = 32'h10;
    tick();
    fe_redirect = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h14; ld_data = 32'hAB;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h10) begin
      failures++; $display("FAIL live_run_we got=%b %h exp=0 10", mem_we, mem_addr); end
    tick();
    checks++; if (ld_ready !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 32'h10) begin
      failures++; $display("FAIL live_enter got=%b %b %h exp=1 1 10", ld_ready, instr_valid, instr_pc); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h14) begin
      failures++; $display("FAIL live_we got=%b %h exp=1 14", mem_we, mem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL live_bubble got=%b exp=0", instr_valid); end
    ld_valid = 1'b0;
    tick();
    checks++; if (ld_ready !== 1'b0 || mem_addr !== 32'h14 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL live_exit got=%b %h %b exp=0 14 0", ld_ready, mem_addr, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hAB || instr_pc !== 32'h14) begin
      failures++; $display("FAIL live_fetch got=%b %h@%h exp=1 ab@14", instr_valid, instr, instr_pc); end
    checks++; if (fetch_cnt !== 32'd4) begin failures++; $display("FAIL live_cnt got=%0d exp=4", fetch_cnt); end
  endtask

  task automatic test_wrap();
    fe_redirect = 1'b1; fe_target = 32'hFFFF_FFFC;
    tick();
    fe_redirect = 1'b0;
    tick();
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'hEE) begin
      failures++; $display("FAIL wrap_top got=%h@%h exp=ee@fffffffc", instr, instr_pc); end
    tick();
    checks++; if (instr_pc !== 32'h0 || instr !== 32'h11) begin
      failures++; $display("FAIL wrap_zero got=%h@%h exp=11@0", instr, instr_pc); end
    checks++; if (align_err !== 1'b1) begin failures++; $display("FAIL align_sticky got=%b exp=1", align_err); end
  endtask

  task automatic test_reset_mid_load();
    ld_valid = 1'b1; ld_addr = 32'h20; ld_data = 32'h77;
    tick();
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL mid_load_enter got=%b exp=1", ld_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({instr_valid, ld_ready, mem_we, align_err} !== 4'b0000) begin
      failures++; $display("FAIL async_ctrl got=%b exp=0000", {instr_valid, ld_ready, mem_we, align_err}); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || fetch_cnt !== 32'h0) begin
      failures++; $display("FAIL async_data got=%h %h %0d exp=0 0 0", instr, instr_pc, fetch_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_no_we got=%b exp=0", mem_we); end
    end
    ld_valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_boot_ready got=%b exp=1", ld_ready); end
    fe_redirect = 1'b1; fe_target = 32'h3;
    tick();
    fe_redirect = 1'b0;
    checks++; if (align_err !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h20) begin
      failures++; $display("FAIL boot_redir_ignored got=%b %b %h exp=0 0 20", align_err, instr_valid, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_live_load();
    test_wrap();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
